// File: rtl/bk_video_pkg.sv
// Shared types for the video cache write path: cache word record and writer state.
package bk_video_pkg;

    localparam int SCREEN_AW   = 15;
    localparam int CLEAR_WORDS = 16384;

    // woff is the full 14-bit cache word index; its MSB equals screen.
    typedef struct packed {
        logic        screen;
        logic [13:0] woff;
        logic [15:0] data;
        logic [1:0]  wtbt;
    } cache_wr_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } scw_state_e;

endpackage

// File: rtl/screen_cache_writer_if.sv
// Video cache write port: registered write strobe plus the consumer's ready.
interface screen_cache_writer_if;
    import bk_video_pkg::*;

    logic [SCREEN_AW-1:0] cache_addr;
    logic [15:0]          cache_data;
    logic [1:0]           cache_wtbt;
    logic                 cache_we;
    logic                 cache_ready;

    modport master (
        output cache_addr, cache_data, cache_wtbt, cache_we,
        input  cache_ready
    );

    modport slave (
        input  cache_addr, cache_data, cache_wtbt, cache_we,
        output cache_ready
    );

endinterface

// File: rtl/scw_fifo.sv
// Snoop buffer: synchronous FIFO of cache write records; a push into a full
// FIFO is taken when a pop happens on the same edge.
module scw_fifo
    import bk_video_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   wb_clk,
    input  logic                   sys_init,
    input  logic                   push,
    input  cache_wr_t              push_data,
    input  logic                   pop,
    output cache_wr_t              pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cache_wr_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // NOTE: the storage array is deliberately left out of reset; only the
    // pointers and count define validity, so the array maps to plain RAM.
    always_ff @(posedge wb_clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk or posedge sys_init) begin
        if (sys_init) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/screen_cache_writer.sv
// Snoops CPU writes to the two screen pages and forwards them to the video
// cache port; a clear sequencer zeroes both screens after reset or on request.
module screen_cache_writer
    import bk_video_pkg::*;
#(
    parameter logic [2:0] SCREEN0_PAGE   = 3'd1,
    parameter logic [2:0] SCREEN1_PAGE   = 3'd7,
    parameter int         FIFO_DEPTH     = 4,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic                        wb_clk,
    input  logic                        sys_init,
    input  logic                        mem_we,
    input  logic [16:0]                 mem_addr,
    input  logic [15:0]                 mem_data,
    input  logic [1:0]                  mem_wtbt,
    input  logic                        clear_req,
    screen_cache_writer_if.master       cache,
    output logic                        clear_busy,
    output logic                        overflow
);

    scw_state_e                  state;
    logic [13:0]                 clr_ptr;
    logic [2:0]                  page;
    logic                        hit_s0;
    logic                        hit_s1;
    logic                        hit;
    logic                        screen;
    cache_wr_t                   fifo_wr;
    cache_wr_t                   fifo_rd;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_pop;
    logic                        fifo_drop;
    logic                        unused_bits;

    assign page    = mem_addr[16:14];
    assign hit_s0  = (page == SCREEN0_PAGE);
    assign hit_s1  = (page == SCREEN1_PAGE);
    assign hit     = mem_we && (mem_wtbt != 2'b00) && (hit_s0 || hit_s1);
    assign screen  = hit_s1 && !hit_s0;
    assign fifo_wr = '{screen: screen, woff: {screen, mem_addr[13:1]},
                       data: mem_data, wtbt: mem_wtbt};

    // Must mirror the IDLE branch below exactly: a pop always becomes a write.
    assign fifo_pop  = !clear_req && cache.cache_ready && (state == IDLE) && !fifo_empty;
    assign fifo_drop = hit && fifo_full && !fifo_pop;

    assign unused_bits = ^{mem_addr[0], fifo_rd.screen, fifo_count};

    scw_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .wb_clk    (wb_clk),
        .sys_init  (sys_init),
        .push      (hit),
        .push_data (fifo_wr),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge wb_clk or posedge sys_init) begin
        if (sys_init) begin
            state            <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clear_busy       <= CLEAR_ON_RESET;
            clr_ptr          <= '0;
            overflow         <= 1'b0;
            cache.cache_addr <= '0;
            cache.cache_data <= '0;
            cache.cache_wtbt <= '0;
            cache.cache_we   <= 1'b0;
        end else begin
            cache.cache_we <= 1'b0;
            if (fifo_drop) overflow <= 1'b1;

            if (clear_req) begin
                state      <= CLEAR;
                clr_ptr    <= '0;
                clear_busy <= 1'b1;
            end else if (cache.cache_ready) begin
                if (state == CLEAR) begin
                    cache.cache_addr <= {clr_ptr, 1'b0};
                    cache.cache_data <= '0;
                    cache.cache_wtbt <= 2'b11;
                    cache.cache_we   <= 1'b1;
                    clr_ptr          <= clr_ptr + 1'b1;
                    if (clr_ptr == 14'(CLEAR_WORDS - 1)) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                    end
                end else if (!fifo_empty) begin
                    cache.cache_addr <= {fifo_rd.woff, 1'b0};
                    cache.cache_data <= fifo_rd.data;
                    cache.cache_wtbt <= fifo_rd.wtbt;
                    cache.cache_we   <= 1'b1;
                end
            end
        end
    end

endmodule
